// File: rtl/playback_ctrl_pkg.sv
// rtl/playback_ctrl_pkg.sv - shared state encoding, note codes and beat period helper
//
// Purpose: common definitions for playback_ctrl and its beat_gen divider.
// Contents:
//   state_e      - player states (STOPPED, PLAYING, PAUSED)
//   NOTE_*       - 4-bit note codes, NOTE_NONE = silence, C4..C5 = one octave
//   beat_period  - clock cycles per beat for a given base period and tempo
package playback_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_B4   = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  // Each tempo step halves the beat period.
  function automatic logic [31:0] beat_period(input logic [31:0] base, input logic [1:0] tempo);
    return base >> tempo;
  endfunction

endpackage

// File: rtl/playback_ctrl_beat_gen.sv
// rtl/playback_ctrl_beat_gen.sv - tempo divider producing one strobe per beat
//
// Purpose: counts clock cycles while enabled and fires once per beat period.
// Ports:
//   CLK    in   system clock, rising edge
//   RESET  in   synchronous active-high reset
//   EN     in   count this cycle (player is running)
//   CLR    in   force the counter back to zero (wins over EN)
//   TEMPO  in   [1:0] period = BASE_TICKS >> TEMPO
//   TICK   out  combinational: this cycle completes a beat (step advances on this edge)
//   BEAT   out  registered one-cycle strobe, high the cycle after TICK
module beat_gen #(
  parameter int unsigned BASE_TICKS = 25_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       CLR,
  input  logic [1:0] TEMPO,
  output logic       TICK,
  output logic       BEAT
);
  import playback_ctrl_pkg::*;

  localparam int unsigned CW = $clog2(BASE_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          beat_q, beat_d;
  logic [31:0]   period;

  always_comb begin
    period = beat_period(32'(BASE_TICKS), TEMPO);
    // Greater-or-equal rather than equality: if TEMPO shortens the period while the
    // count is already past the new end, the beat fires at once instead of wrapping.
    TICK   = EN && !CLR && ((32'(cnt_q) + 32'd1) >= period);
    cnt_d  = cnt_q;
    beat_d = 1'b0;
    if (CLR) begin
      cnt_d = '0;
    end else if (TICK) begin
      cnt_d  = '0;
      beat_d = 1'b1;
    end else if (EN) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

  assign BEAT = beat_q;

endmodule

// File: rtl/playback_ctrl.sv
// rtl/playback_ctrl.sv - song playback state machine with note arbitration
//
// Purpose: steps through a song table one step per beat, with play/pause/stop,
//          loop or stop-at-end, and a manual keyboard override.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   MODE                1 = manual keyboard only, 0 = auto-play allowed
//   PLAY, STOP          one-cycle pulses: start/toggle pause, abort
//   LOOP                1 = wrap at song end, 0 = stop at song end
//   TEMPO [1:0]         beat period = BASE_TICKS >> TEMPO
//   KEY_NOTE [3:0]      manual note, 0 = none
//   SONG_NOTE [3:0]     song table note at the current STEP
//   STEP [5:0]          song table address
//   NOTE [3:0]          registered arbitrated note
//   BEAT                one-cycle strobe per beat
//   PLAYING             state is PLAYING
module playback_ctrl #(
  parameter int unsigned BASE_TICKS = 25_000_000,
  parameter int unsigned SONG_LEN   = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MODE,
  input  logic       PLAY,
  input  logic       STOP,
  input  logic       LOOP,
  input  logic [1:0] TEMPO,
  input  logic [3:0] KEY_NOTE,
  input  logic [3:0] SONG_NOTE,
  output logic [5:0] STEP,
  output logic [3:0] NOTE,
  output logic       BEAT,
  output logic       PLAYING
);
  import playback_ctrl_pkg::*;

  localparam logic [5:0] LAST_STEP = 6'(SONG_LEN - 1);

  state_e     state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [3:0] note_q, note_d;
  logic       bg_en, bg_clr, bg_tick;

  beat_gen #(
    .BASE_TICKS (BASE_TICKS)
  ) u_beat_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (bg_en),
    .CLR   (bg_clr),
    .TEMPO (TEMPO),
    .TICK  (bg_tick),
    .BEAT  (BEAT)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    bg_en   = 1'b0;
    bg_clr  = 1'b0;
    note_d  = (state_q == ST_PLAYING && !MODE) ? SONG_NOTE : KEY_NOTE;

    if (MODE || STOP) begin
      state_d = ST_STOPPED;
      step_d  = '0;
      bg_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (PLAY) begin
            state_d = ST_PLAYING;
            step_d  = '0;
            bg_clr  = 1'b1;
          end
        end
        ST_PLAYING: begin
          if (PLAY) begin
            // Pausing freezes the divider: the count is held, not advanced.
            state_d = ST_PAUSED;
          end else begin
            bg_en = 1'b1;
            if (bg_tick) begin
              if (step_q == LAST_STEP) begin
                // The end-of-song beat still strobes BEAT even when it stops the song.
                step_d = '0;
                if (!LOOP) state_d = ST_STOPPED;
              end else begin
                step_d = step_q + 6'd1;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (PLAY) state_d = ST_PLAYING;
        end
        default: begin
          state_d = ST_STOPPED;
          step_d  = '0;
          bg_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_STOPPED;
      step_q  <= '0;
      note_q  <= NOTE_NONE;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      note_q  <= note_d;
    end
  end

  assign STEP    = step_q;
  assign NOTE    = note_q;
  assign PLAYING = (state_q == ST_PLAYING);

endmodule

// File: tb/tb_playback_ctrl.sv
// tb/tb_playback_ctrl.sv - self-checking bench for playback_ctrl
module tb_playback_ctrl;

  localparam int BT = 8;
  localparam int SL = 4;
  localparam int M_STOPPED = 0;
  localparam int M_PLAYING = 1;
  localparam int M_PAUSED  = 2;

  logic       CLK = 1'b0;
  logic       RESET, MODE, PLAY, STOP, LOOP;
  logic [1:0] TEMPO;
  logic [3:0] KEY_NOTE, SONG_NOTE;
  logic [5:0] STEP;
  logic [3:0] NOTE;
  logic       BEAT, PLAYING;

  logic [3:0] song [0:63];
  assign SONG_NOTE = song[STEP];

  playback_ctrl #(.BASE_TICKS(BT), .SONG_LEN(SL)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .PLAY(PLAY), .STOP(STOP), .LOOP(LOOP),
    .TEMPO(TEMPO), .KEY_NOTE(KEY_NOTE), .SONG_NOTE(SONG_NOTE),
    .STEP(STEP), .NOTE(NOTE), .BEAT(BEAT), .PLAYING(PLAYING)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: player state, cycles elapsed in the current beat, song position.
  int         m_state = M_STOPPED;
  int         m_elapsed = 0;
  int         m_step = 0;
  logic       m_beat = 1'b0;
  logic [3:0] m_note = 4'd0;

  wire [11:0] obs = {STEP, NOTE, BEAT, PLAYING};

  function automatic logic [11:0] expv();
    return {6'(m_step), m_note, m_beat, (m_state == M_PLAYING)};
  endfunction

  function automatic string show(input logic [11:0] v);
    return $sformatf("STEP=%0d NOTE=%0d BEAT=%0b PLAYING=%0b", v[11:6], v[5:2], v[1], v[0]);
  endfunction

  task automatic model_edge();
    int period;
    logic [3:0] heard;
    period = BT >> TEMPO;
    heard  = (m_state == M_PLAYING && !MODE) ? song[m_step] : KEY_NOTE;
    m_beat = 1'b0;
    if (RESET) begin
      m_state = M_STOPPED; m_elapsed = 0; m_step = 0; m_note = 4'd0;
    end else begin
      m_note = heard;
      if (MODE || STOP) begin
        m_state = M_STOPPED; m_elapsed = 0; m_step = 0;
      end else if (m_state == M_STOPPED) begin
        if (PLAY) begin m_state = M_PLAYING; m_elapsed = 0; m_step = 0; end
      end else if (m_state == M_PAUSED) begin
        if (PLAY) m_state = M_PLAYING;
      end else if (PLAY) begin
        m_state = M_PAUSED;
      end else if (m_elapsed + 1 >= period) begin
        m_beat = 1'b1;
        m_elapsed = 0;
        if (m_step == SL - 1) begin
          m_step = 0;
          if (!LOOP) m_state = M_STOPPED;
        end else begin
          m_step = m_step + 1;
        end
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic pulse_play();
    PLAY = 1'b1; clk_step(); PLAY = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1; clk_step(); STOP = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; PLAY = 1'b1; MODE = 1'b0; KEY_NOTE = 4'd9;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      n_checks++;
      if (obs !== 12'h000) $display("FAIL reset_hold: got %s want %s", show(obs), show(12'h000));
      else n_pass++;
    end
    RESET = 1'b0; PLAY = 1'b0; KEY_NOTE = 4'd0;
    clk_step();
    n_checks++;
    if (obs !== 12'h000) $display("FAIL reset_release: got %s want %s", show(obs), show(12'h000));
    else n_pass++;
  endtask

  task automatic test_loop_play();
    MODE = 1'b0; LOOP = 1'b1; TEMPO = 2'd0;
    pulse_stop();
    pulse_play();
    n_checks++;
    if (PLAYING !== 1'b1 || STEP !== 6'd0) $display("FAIL loop_start: got %s want PLAYING=1 STEP=0", show(obs));
    else n_pass++;
    for (int c = 1; c <= 40; c++) begin
      clk_step();
      KEY_NOTE = 4'($urandom_range(0, 15));
      n_checks++;
      if (obs !== expv()) $display("FAIL loop_model c%0d: got %s want %s", c, show(obs), show(expv()));
      else n_pass++;
      n_checks++;
      if (BEAT !== ((c % 8) == 0)) $display("FAIL loop_beat_period c%0d: got BEAT=%0b want %0b", c, BEAT, (c % 8) == 0);
      else n_pass++;
      if ((c % 8) == 0) begin
        n_checks++;
        if (STEP !== 6'((c / 8) % SL)) $display("FAIL loop_step c%0d: got STEP=%0d want %0d", c, STEP, (c / 8) % SL);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pause();
    int first;
    LOOP = 1'b1; TEMPO = 2'd0;
    pulse_stop();
    pulse_play();
    for (int c = 1; c <= 27; c++) begin
      clk_step();
      n_checks++;
      if (obs !== expv()) $display("FAIL pause_run c%0d: got %s want %s", c, show(obs), show(expv()));
      else n_pass++;
    end
    pulse_play();
    for (int i = 1; i <= 20; i++) begin
      clk_step();
      n_checks++;
      if (STEP !== 6'd3 || PLAYING !== 1'b0 || BEAT !== 1'b0)
        $display("FAIL pause_hold i%0d: got %s want STEP=3 BEAT=0 PLAYING=0", i, show(obs));
      else n_pass++;
    end
    pulse_play();
    n_checks++;
    if (PLAYING !== 1'b1 || STEP !== 6'd3) $display("FAIL pause_resume: got %s want STEP=3 PLAYING=1", show(obs));
    else n_pass++;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      clk_step();
      if (BEAT === 1'b1 && first < 0) first = k;
      n_checks++;
      if (obs !== expv()) $display("FAIL pause_after k%0d: got %s want %s", k, show(obs), show(expv()));
      else n_pass++;
    end
    n_checks++;
    if (first != 5) $display("FAIL pause_beat_latency: got %0d cycles (-1 = none in 12) want 5", first);
    else n_pass++;
  endtask

  task automatic test_no_loop();
    LOOP = 1'b0; TEMPO = 2'd0;
    pulse_stop();
    pulse_play();
    for (int c = 1; c <= 40; c++) begin
      clk_step();
      n_checks++;
      if (obs !== expv()) $display("FAIL noloop_model c%0d: got %s want %s", c, show(obs), show(expv()));
      else n_pass++;
      if (c == 32) begin
        n_checks++;
        if (BEAT !== 1'b1 || PLAYING !== 1'b0 || STEP !== 6'd0)
          $display("FAIL noloop_end: got %s want STEP=0 BEAT=1 PLAYING=0", show(obs));
        else n_pass++;
      end
    end
    LOOP = 1'b1;
  endtask

  task automatic test_stop_priority();
    LOOP = 1'b1; TEMPO = 2'd0; MODE = 1'b0;
    pulse_stop();
    pulse_play();
    for (int c = 1; c <= 10; c++) clk_step();
    PLAY = 1'b1; STOP = 1'b1;
    clk_step();
    PLAY = 1'b0; STOP = 1'b0;
    n_checks++;
    if (STEP !== 6'd0 || PLAYING !== 1'b0 || BEAT !== 1'b0)
      $display("FAIL stop_over_play: got %s want STEP=0 BEAT=0 PLAYING=0", show(obs));
    else n_pass++;
    MODE = 1'b1; KEY_NOTE = 4'd5;
    clk_step();
    n_checks++;
    if (NOTE !== 4'd5) $display("FAIL manual_note: got NOTE=%0d want 5", NOTE);
    else n_pass++;
    pulse_play();
    n_checks++;
    if (PLAYING !== 1'b0 || STEP !== 6'd0) $display("FAIL manual_ignores_play: got %s want PLAYING=0 STEP=0", show(obs));
    else n_pass++;
    MODE = 1'b0;
    clk_step();
  endtask

  task automatic test_tempo_switch();
    LOOP = 1'b1; TEMPO = 2'd0;
    pulse_stop();
    pulse_play();
    for (int c = 1; c <= 5; c++) clk_step();
    TEMPO = 2'd2;
    clk_step();
    n_checks++;
    if (BEAT !== 1'b1 || STEP !== 6'd1) $display("FAIL tempo_jump: got %s want BEAT=1 STEP=1", show(obs));
    else n_pass++;
    for (int c = 1; c <= 6; c++) begin
      clk_step();
      n_checks++;
      if (obs !== expv()) $display("FAIL tempo_model c%0d: got %s want %s", c, show(obs), show(expv()));
      else n_pass++;
    end
    TEMPO = 2'd0;
  endtask

  task automatic test_reset_mid();
    LOOP = 1'b1; TEMPO = 2'd0;
    pulse_stop();
    pulse_play();
    for (int c = 1; c <= 18; c++) clk_step();
    n_checks++;
    if (STEP !== 6'd2) $display("FAIL reset_mid_setup: got STEP=%0d want 2", STEP);
    else n_pass++;
    RESET = 1'b1; PLAY = 1'b1; KEY_NOTE = 4'd7;
    clk_step();
    RESET = 1'b0; PLAY = 1'b0; KEY_NOTE = 4'd0;
    n_checks++;
    if (obs !== 12'h000) $display("FAIL reset_mid: got %s want %s", show(obs), show(12'h000));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      PLAY     = ($urandom_range(0, 11) == 0);
      STOP     = ($urandom_range(0, 49) == 0);
      RESET    = ($urandom_range(0, 299) == 0);
      KEY_NOTE = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) MODE = ~MODE;
      if ($urandom_range(0, 49) == 0) LOOP = ~LOOP;
      if ($urandom_range(0, 31) == 0) TEMPO = 2'($urandom_range(0, 3));
      clk_step();
      n_checks++;
      if (obs !== expv()) $display("FAIL random c%0d: got %s want %s", c, show(obs), show(expv()));
      else n_pass++;
    end
    PLAY = 1'b0; STOP = 1'b0; RESET = 1'b0; MODE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; MODE = 1'b0; PLAY = 1'b0; STOP = 1'b0; LOOP = 1'b1;
    TEMPO = 2'd0; KEY_NOTE = 4'd0;
    for (int i = 0; i < 64; i++) song[i] = 4'($urandom_range(1, 8));
    test_reset();
    test_loop_play();
    test_pause();
    test_no_loop();
    test_stop_priority();
    test_tempo_switch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
